// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// the length-flag bit position and default geometry.
package instr_fetch_unit_pkg;

  localparam int DEF_WORD_LENGTH   = 16;
  localparam int DEF_ADDRESS_SPACE = 21;

  // Bit of the first instruction word that marks a 32-bit instruction.
  localparam int LONG_BIT = 15;

  typedef enum logic [2:0] {
    S_REQ0  = 3'd0,
    S_CAP0  = 3'd1,
    S_REQ1  = 3'd2,
    S_CAP1  = 3'd3,
    S_VALID = 3'd4
  } fetch_state_e;

endpackage : instr_fetch_unit_pkg

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, reads 16-bit words from a one-cycle-latency
// memory and presents short/long instructions to decode via valid/ready.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                       WORD_LENGTH   = DEF_WORD_LENGTH,
  parameter int                       ADDRESS_SPACE = DEF_ADDRESS_SPACE,
  parameter logic [ADDRESS_SPACE-1:0] RESET_PC      = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [ADDRESS_SPACE-1:0]   mem_addr,
  output logic                       mem_en,
  input  logic [WORD_LENGTH-1:0]     mem_data,
  input  logic                       redirect_valid,
  input  logic [ADDRESS_SPACE-1:0]   redirect_pc,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [2*WORD_LENGTH-1:0]   out_instr,
  output logic [ADDRESS_SPACE-1:0]   out_pc,
  output logic                       out_is_long
);

  fetch_state_e               state_q, state_d;
  logic [ADDRESS_SPACE-1:0]   pc_q, pc_d, pc_next;
  logic [WORD_LENGTH-1:0]     word0_q, word0_d;
  logic [WORD_LENGTH-1:0]     word1_q, word1_d;
  logic                       long_q, long_d;
  logic                       started_q;

  // Single incrementer: +1 addresses the second word in REQ1 and steps past a
  // short instruction; +2 steps past a long one. Wraps modulo 2^ADDRESS_SPACE.
  assign pc_next = pc_q + (((state_q == S_VALID) && long_q) ? ADDRESS_SPACE'(2)
                                                            : ADDRESS_SPACE'(1));

  // started_q keeps REQ0 from issuing while reset is still held, so the first
  // request appears after the first edge following reset release.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no path leaves a signal unassigned (no latch).
    mem_en   = 1'b0;
    mem_addr = '0;
    if ((state_q == S_REQ0) && started_q) begin
      mem_en   = 1'b1;
      mem_addr = pc_q;
    end else if (state_q == S_REQ1) begin
      mem_en   = 1'b1;
      mem_addr = pc_next;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    word0_d = word0_q;
    word1_d = word1_q;
    long_d  = long_q;
    unique case (state_q)
      S_REQ0:  if (started_q) state_d = S_CAP0;
      S_CAP0: begin
        word0_d = mem_data;
        long_d  = mem_data[LONG_BIT];
        state_d = mem_data[LONG_BIT] ? S_REQ1 : S_VALID;
      end
      S_REQ1:  state_d = S_CAP1;
      S_CAP1: begin
        word1_d = mem_data;
        state_d = S_VALID;
      end
      S_VALID: begin
        if (out_ready) begin
          pc_d    = pc_next;
          state_d = S_REQ0;
        end
      end
      default: state_d = S_REQ0;
    endcase
    // A redirect discards any in-flight or held instruction and wins over the
    // handshake increment.
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      state_d = S_REQ0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking '<='; the word latches are
      // plain registers and are cleared here like the rest of the state.
      state_q   <= S_REQ0;
      pc_q      <= RESET_PC;
      word0_q   <= '0;
      word1_q   <= '0;
      long_q    <= 1'b0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      word0_q   <= word0_d;
      word1_q   <= word1_d;
      long_q    <= long_d;
      started_q <= 1'b1;
    end
  end

  assign out_valid   = (state_q == S_VALID);
  assign out_pc      = out_valid ? pc_q : '0;
  assign out_is_long = out_valid & long_q;
  assign out_instr   = !out_valid ? '0
                     : long_q     ? {word0_q, word1_q}
                                  : {{WORD_LENGTH{1'b0}}, word0_q};

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a vector table of fetches plus
// hand-written reset, stall, redirect and wrap-around sequences.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [20:0] mem_addr;
  logic        mem_en;
  logic [15:0] mem_data;
  logic        redirect_valid;
  logic [20:0] redirect_pc;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [20:0] out_pc;
  logic        out_is_long;

  int n_checks = 0;
  int n_pass   = 0;

  instr_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .mem_addr       (mem_addr),
    .mem_en         (mem_en),
    .mem_data       (mem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_is_long    (out_is_long)
  );

  always #5 clk = ~clk;

  // Sparse instruction memory, one-cycle read latency; junk when not enabled.
  logic [15:0] mem [logic [20:0]];
  always @(posedge clk) begin
    if (mem_en) mem_data <= mem.exists(mem_addr) ? mem[mem_addr] : 16'h0000;
    else        mem_data <= 16'hDEAD;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [20:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  // Called one cycle after the redirect/request edge; cyc counts cycles since it.
  task automatic run_to_valid(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 12) begin
      step();
      cyc++;
    end
  endtask

  typedef struct {
    logic [20:0] addr;
    logic [15:0] w0;
    logic [15:0] w1;
    logic [31:0] exp_instr;
    logic        exp_long;
    logic [20:0] exp_next;
    int          stall;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int          cyc;
    logic [20:0] a1;

    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b1;
    mem_data       = 16'hDEAD;
    mem[21'h000000] = 16'h1234;

    // Reset state.
    step();
    step();
    check("rst_mem_en",    mem_en,      0);
    check("rst_mem_addr",  mem_addr,    0);
    check("rst_valid",     out_valid,   0);
    check("rst_instr",     out_instr,   0);
    check("rst_pc",        out_pc,      0);
    check("rst_long",      out_is_long, 0);

    // Release at cycle 0; first request cycle 1, short instruction valid cycle 3.
    reset = 1'b1;
    step();
    check("c1_mem_en",   mem_en,   1);
    check("c1_mem_addr", mem_addr, 0);
    step();
    check("c2_mem_en",   mem_en,    0);
    check("c2_valid",    out_valid, 0);
    step();
    check("c3_valid",    out_valid,   1);
    check("c3_instr",    out_instr,   32'h0000_1234);
    check("c3_pc",       out_pc,      0);
    check("c3_long",     out_is_long, 0);
    step();
    out_ready = 1'b0;
    check("c4_mem_en",   mem_en,   1);
    check("c4_mem_addr", mem_addr, 1);

    mem[21'h000000] = 16'h0001;
    vecs[0] = '{21'h000004, 16'h8001, 16'hBEEF, 32'h8001_BEEF, 1'b1, 21'h000006, 5};
    vecs[1] = '{21'h1FFFFF, 16'h8000, 16'h0001, 32'h8000_0001, 1'b1, 21'h000001, 0};
    vecs[2] = '{21'h1FFFFE, 16'h7FFF, 16'h0000, 32'h0000_7FFF, 1'b0, 21'h1FFFFF, 2};
    vecs[3] = '{21'h000ABC, 16'hFFFF, 16'h0000, 32'hFFFF_0000, 1'b1, 21'h000ABE, 0};
    vecs[4] = '{21'h000100, 16'h0042, 16'h0000, 32'h0000_0042, 1'b0, 21'h000101, 0};
    foreach (vecs[i]) begin
      mem[vecs[i].addr] = vecs[i].w0;
      if (vecs[i].exp_long) begin
        a1 = vecs[i].addr + 21'd1;
        mem[a1] = vecs[i].w1;
      end
    end

    foreach (vecs[i]) begin
      out_ready = 1'b0;
      do_redirect(vecs[i].addr);
      check($sformatf("v%0d_req_en", i),   mem_en,   1);
      check($sformatf("v%0d_req_addr", i), mem_addr, vecs[i].addr);
      run_to_valid(cyc);
      check($sformatf("v%0d_latency", i), cyc, vecs[i].exp_long ? 5 : 3);
      check($sformatf("v%0d_instr", i),   out_instr,   vecs[i].exp_instr);
      check($sformatf("v%0d_pc", i),      out_pc,      vecs[i].addr);
      check($sformatf("v%0d_long", i),    out_is_long, vecs[i].exp_long);
      for (int s = 0; s < vecs[i].stall; s++) begin
        step();
        check($sformatf("v%0d_stall%0d_valid", i, s), out_valid, 1);
        check($sformatf("v%0d_stall%0d_instr", i, s), out_instr, vecs[i].exp_instr);
        check($sformatf("v%0d_stall%0d_en", i, s),    mem_en,    0);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check($sformatf("v%0d_next_valid", i), out_valid, 0);
      check($sformatf("v%0d_next_en", i),    mem_en,    1);
      check($sformatf("v%0d_next_addr", i),  mem_addr,  vecs[i].exp_next);
    end

    // Redirect during CAP0 of a long fetch: the long instruction is never shown.
    do_redirect(21'h000004);
    step();
    check("rdc0_mem_en", mem_en, 0);
    out_ready = 1'b1;
    do_redirect(21'h000100);
    check("rdc0_req_en",   mem_en,    1);
    check("rdc0_req_addr", mem_addr,  21'h000100);
    check("rdc0_valid",    out_valid, 0);
    run_to_valid(cyc);
    check("rdc0_latency", cyc,       3);
    check("rdc0_pc",      out_pc,    21'h000100);
    check("rdc0_instr",   out_instr, 32'h0000_0042);

    // Handshake and redirect together: redirect target wins the next request.
    redirect_valid = 1'b1;
    redirect_pc    = 21'h000200;
    step();
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    check("hsrd_valid", out_valid, 0);
    check("hsrd_addr",  mem_addr,  21'h000200);

    // Reset asserted while in REQ1 of a long fetch.
    do_redirect(21'h000004);
    step();
    step();
    check("rq1_mem_en",   mem_en,   1);
    check("rq1_mem_addr", mem_addr, 21'h000005);
    reset = 1'b0;
    #1;
    check("rq1_rst_en",    mem_en,    0);
    check("rq1_rst_addr",  mem_addr,  0);
    check("rq1_rst_valid", out_valid, 0);
    step();
    reset = 1'b1;
    step();
    check("rq1_restart_en",   mem_en,   1);
    check("rq1_restart_addr", mem_addr, 0);
    run_to_valid(cyc);
    check("rq1_restart_lat",   cyc,       3);
    check("rq1_restart_instr", out_instr, 32'h0000_0001);
    check("rq1_restart_pc",    out_pc,    0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_instr_fetch_unit
